sha256_msg_padder: RTL and testbench

//  Front-end pad stage of the SHA-256 datapath. Sits between the word-streaming message source
//  (in_data/in_valid/in_ready/last_word/last_numbyte) and the message schedule/compression core.

---
 rtl/sha256_msg_padder_pkg.sv | 31 +++
 rtl/sha256_msg_padder_if.sv | 28 ++
 rtl/sha256_msg_padder.sv | 130 +++++++++++++
 tb/tb_sha256_msg_padder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sha256_msg_padder_pkg.sv
// Shared types and constants for the SHA-256 message pad stage.
// Also holds the helper that closes off a partial final word.
package sha256_msg_padder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD80,
    ZERO,
    LENHI,
    LENLO
  } pad_state_e;

  localparam logic [7:0] SHA256_PAD_BYTE  = 8'h80;
  localparam int         SHA256_BLK_WORDS = 16;

  // Keep the MSB-aligned valid bytes, put 0x80 in the first invalid byte, clear the rest.
  // numbyte 0 means a full word, so it is returned unchanged.
  function automatic logic [31:0] sha256_pad_last(input logic [31:0] word,
                                                  input logic [1:0]  numbyte);
    logic [31:0] res;
    case (numbyte)
      2'd1:    res = {word[31:24], SHA256_PAD_BYTE, 16'h0000};
      2'd2:    res = {word[31:16], SHA256_PAD_BYTE, 8'h00};
      2'd3:    res = {word[31:8],  SHA256_PAD_BYTE};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Word-stream bundle between the message source, the pad stage and the schedule core.
// The padder uses the slave view; the environment around it uses the master view.
interface sha256_msg_padder_if;

  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        last_word;
  logic [1:0]  last_numbyte;

  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_word_idx;
  logic        out_blk_last;
  logic        out_msg_last;

  modport master (
    output in_data, in_valid, last_word, last_numbyte, out_ready,
    input  in_ready, out_data, out_valid, out_word_idx, out_blk_last, out_msg_last
  );

  modport slave (
    input  in_data, in_valid, last_word, last_numbyte, out_ready,
    output in_ready, out_data, out_valid, out_word_idx, out_blk_last, out_msg_last
  );

endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 pad stage: forwards message words, then appends 0x80, zero fill and the 64-bit
// bit length, tagging every output word with its index inside the 512-bit block.
module sha256_msg_padder
  import sha256_msg_padder_pkg::*;
#(
  parameter int BYTE_CNT_W = 61
) (
  input  logic                 clk,
  input  logic                 rst,
  sha256_msg_padder_if.slave   bus
);

  localparam logic [3:0] LAST_IDX    = 4'(SHA256_BLK_WORDS - 1);
  localparam logic [3:0] PRE_LEN_IDX = 4'(SHA256_BLK_WORDS - 3);

  pad_state_e            state, state_nxt;
  logic [BYTE_CNT_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [BYTE_CNT_W-1:0] add_bytes;
  logic [3:0]            idx, idx_nxt;
  logic [31:0]           data_q, data_nxt;
  logic                  valid_q, valid_nxt;
  logic [3:0]            widx_q, widx_nxt;
  logic                  blk_q, blk_nxt;
  logic                  msg_q, msg_nxt;
  logic                  advance;
  logic                  emit;
  logic [63:0]           bit_len;
  pad_state_e            after_pad;

  // The output register may load whenever it is empty or its word is being taken.
  assign advance      = ~valid_q | bus.out_ready;
  assign bus.in_ready = (state == DATA) & advance;

  assign bit_len   = 64'({byte_cnt, 3'b000});
  assign add_bytes = (bus.last_word && (bus.last_numbyte != 2'd0))
                     ? BYTE_CNT_W'(bus.last_numbyte) : BYTE_CNT_W'(4);

  // Once the 0x80 marker is out, zero-fill until the slot just before the length words.
  assign after_pad = (idx == PRE_LEN_IDX) ? LENHI : ZERO;

  assign bus.out_data     = data_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_word_idx = widx_q;
  assign bus.out_blk_last = blk_q;
  assign bus.out_msg_last = msg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      idx      <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      widx_q   <= '0;
      blk_q    <= 1'b0;
      msg_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      idx      <= idx_nxt;
      data_q   <= data_nxt;
      valid_q  <= valid_nxt;
      widx_q   <= widx_nxt;
      blk_q    <= blk_nxt;
      msg_q    <= msg_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    idx_nxt      = idx;
    data_nxt     = data_q;
    valid_nxt    = valid_q;
    widx_nxt     = widx_q;
    blk_nxt      = blk_q;
    msg_nxt      = msg_q;
    emit         = 1'b0;

    if (advance) begin
      valid_nxt = 1'b0;
      unique case (state)
        IDLE: state_nxt = DATA;
        DATA: begin
          if (bus.in_valid) begin
            emit         = 1'b1;
            byte_cnt_nxt = byte_cnt + add_bytes;
            if (bus.last_word) begin
              data_nxt  = sha256_pad_last(bus.in_data, bus.last_numbyte);
              state_nxt = (bus.last_numbyte == 2'd0) ? PAD80 : after_pad;
            end else begin
              data_nxt = bus.in_data;
            end
          end
        end
        PAD80: begin
          emit      = 1'b1;
          data_nxt  = {SHA256_PAD_BYTE, 24'h000000};
          state_nxt = after_pad;
        end
        ZERO: begin
          emit      = 1'b1;
          data_nxt  = '0;
          state_nxt = after_pad;
        end
        LENHI: begin
          emit      = 1'b1;
          data_nxt  = bit_len[63:32];
          state_nxt = LENLO;
        end
        LENLO: begin
          emit         = 1'b1;
          data_nxt     = bit_len[31:0];
          byte_cnt_nxt = '0;
          state_nxt    = DATA;
        end
        default: state_nxt = IDLE;
      endcase

      if (emit) begin
        valid_nxt = 1'b1;
        widx_nxt  = idx;
        blk_nxt   = (idx == LAST_IDX);
        msg_nxt   = (state == LENLO);
        idx_nxt   = idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: a byte-level padding model predicts every
// output word; a table of messages plus a mid-message reset sequence drive it.
`timescale 1ns/1ps
module tb_sha256_msg_padder;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        blk;
    logic        msg;
  } beat_t;

  typedef struct {
    int          n_words;
    logic [1:0]  last_nb;
    logic [31:0] last_data;
    int          exp_out;
    logic [31:0] exp_len_lo;
    bit          throttle;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  sha256_msg_padder_if bus();

  sha256_msg_padder #(.BYTE_CNT_W(61)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  beat_t       sb[$];
  logic [31:0] msg_words[$];
  bit          throttle_on = 1'b0;
  int          words_seen  = 0;
  logic [31:0] last_len_lo = '0;
  bit          prev_stall  = 1'b0;
  beat_t       held;
  beat_t       cur;
  beat_t       exp_beat;
  vec_t        vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Independent byte-level padding model: message bytes, 0x80, zeros to 56 mod 64, length.
  task automatic buildExpected(input logic [1:0] last_nb);
    logic [7:0]  b[$];
    int          len;
    int          nw;
    int          nb;
    logic [63:0] bits;
    beat_t       e;
    for (int i = 0; i < msg_words.size(); i++) begin
      nb = ((i == msg_words.size() - 1) && (last_nb != 2'd0)) ? int'(last_nb) : 4;
      for (int k = 0; k < nb; k++) b.push_back(msg_words[i][31-8*k -: 8]);
    end
    len  = b.size();
    bits = 64'(len) * 64'd8;
    b.push_back(8'h80);
    while ((b.size() % 64) != 56) b.push_back(8'h00);
    for (int k = 7; k >= 0; k--) b.push_back(bits[8*k +: 8]);
    nw = b.size() / 4;
    for (int w = 0; w < nw; w++) begin
      e.data = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
      e.idx  = 4'(w % 16);
      e.blk  = ((w % 16) == 15);
      e.msg  = (w == nw - 1);
      sb.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] last_nb);
    int i     = 0;
    int guard = 0;
    bit fire;
    while (i < msg_words.size() && guard < 5000) begin
      if (throttle_on && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid     = 1'b1;
        bus.in_data      = msg_words[i];
        bus.last_word    = (i == msg_words.size() - 1);
        bus.last_numbyte = bus.last_word ? last_nb : 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (fire) i++;
      guard++;
    end
    bus.in_valid  = 1'b0;
    bus.last_word = 1'b0;
    checkOutput("words_accepted", 64'(i), 64'(msg_words.size()));
  endtask

  task automatic runVector(input vec_t v, input string name);
    int guard = 0;
    msg_words.delete();
    for (int i = 0; i < v.n_words - 1; i++)
      msg_words.push_back({8'(i), 8'(v.n_words), 8'h5A, 8'(i * 7 + 3)});
    msg_words.push_back(v.last_data);
    words_seen  = 0;
    last_len_lo = '0;
    throttle_on = v.throttle;
    buildExpected(v.last_nb);
    applyStimulus(v.last_nb);
    while (sb.size() != 0 && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput({name, "_drain"}, 64'(sb.size()), 64'd0);
    checkOutput({name, "_count"}, 64'(words_seen), 64'(v.exp_out));
    checkOutput({name, "_lenlo"}, 64'(last_len_lo), 64'(v.exp_len_lo));
    throttle_on = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    bus.out_ready = throttle_on ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Output monitor: stall stability, then scoreboard pop on each accepted word.
  always @(negedge clk) begin
    cur = {bus.out_data, bus.out_word_idx, bus.out_blk_last, bus.out_msg_last};
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        checkOutput("stall_hold", 64'({bus.out_valid, cur}), 64'({1'b1, held}));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_word actual=%h expected=none", cur);
        end else begin
          exp_beat = sb.pop_front();
          checkOutput("word", 64'(cur), 64'(exp_beat));
          words_seen++;
          if (cur.msg) last_len_lo = cur.data;
        end
        prev_stall = 1'b0;
      end else if (bus.out_valid) begin
        prev_stall = 1'b1;
        held       = cur;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int guard;
    vecs[0] = '{1,  2'd3, 32'h61626300, 16, 32'h00000018, 1'b0};
    vecs[1] = '{13, 2'd0, 32'h11223344, 16, 32'h000001A0, 1'b0};
    vecs[2] = '{14, 2'd0, 32'h55667788, 32, 32'h000001C0, 1'b0};
    vecs[3] = '{17, 2'd1, 32'hAB000000, 32, 32'h00000208, 1'b0};
    vecs[4] = '{40, 2'd2, 32'hCDEF0000, 48, 32'h000004F0, 1'b0};
    vecs[5] = '{40, 2'd2, 32'hCDEF0000, 48, 32'h000004F0, 1'b1};

    rst              = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_data      = 32'hDEADBEEF;
    bus.last_word    = 1'b1;
    bus.last_numbyte = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state",
                64'({bus.out_valid, bus.out_data, bus.out_word_idx,
                     bus.out_blk_last, bus.out_msg_last, bus.in_ready}), 64'd0);
    bus.in_valid  = 1'b0;
    bus.last_word = 1'b0;
    rst           = 1'b1;

    for (int v = 0; v < 6; v++) runVector(vecs[v], $sformatf("vec%0d", v));

    // Reset while the zero fill of an "abc" block is in flight.
    msg_words.delete();
    msg_words.push_back(32'h61626300);
    buildExpected(2'd3);
    applyStimulus(2'd3);
    guard = 0;
    while (!(bus.out_valid && bus.out_word_idx == 4'd5) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("zero_reached", 64'(bus.out_word_idx), 64'd5);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_reset_clear",
                64'({bus.out_valid, bus.out_data, bus.out_word_idx,
                     bus.out_blk_last, bus.out_msg_last, bus.in_ready}), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    runVector(vecs[0], "abc_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
